// File: rtl/code_led_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : code_led_decoder
//  Description : Registered 3-to-8 one-hot LED decoder with timed display and
//                an all-LED error blink, fed by the 8-3 priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_led_decoder #(
    parameter int HOLD_CYCLES = 16,
    parameter int BLINK_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code_i,
    input  logic       error_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] led_o,
    output logic       done_o
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    localparam logic [HW-1:0] c_HOLD_RELOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] c_HOLD_ONE     = HW'(1);
    localparam logic [BW-1:0] c_BLINK_RELOAD = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] c_BLINK_ONE    = BW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SHOW = 2'd1;
    localparam logic [1:0] c_ERR  = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [7:0]    led_q,       led_d;
    logic          done_q,      done_d;
    logic [HW-1:0] hold_cnt_q,  hold_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        done_d      = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        blink_cnt_d = blink_cnt_q;
        case (state_q)
            c_IDLE: begin
                if (valid_i) begin
                    hold_cnt_d = c_HOLD_RELOAD;
                    // error wins over code: the encoder's code is meaningless then
                    if (error_i) begin
                        state_d     = c_ERR;
                        led_d       = 8'hFF;
                        blink_cnt_d = c_BLINK_RELOAD;
                    end else begin
                        state_d = c_SHOW;
                        led_d   = 8'h01 << code_i;
                    end
                end
            end
            c_SHOW, c_ERR: begin
                if (hold_cnt_q == '0) begin
                    state_d = c_IDLE;
                    led_d   = 8'h00;
                    done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - c_HOLD_ONE;
                    if (state_q == c_ERR) begin
                        if (blink_cnt_q == '0) begin
                            led_d       = ~led_q;
                            blink_cnt_d = c_BLINK_RELOAD;
                        end else begin
                            blink_cnt_d = blink_cnt_q - c_BLINK_ONE;
                        end
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                led_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            led_q       <= 8'h00;
            done_q      <= 1'b0;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            done_q      <= done_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign ready_o = (state_q == c_IDLE);
    assign led_o   = led_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_code_led_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_led_decoder
//  Description : Vector-table bench for code_led_decoder (HOLD=16 and HOLD=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_led_decoder;

    typedef struct {
        string      name;
        logic       valid;
        logic       error;
        logic [2:0] code;
        logic [7:0] led;
        logic       ready;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] a_code = '0, b_code = '0;
    logic       a_error = 1'b0, b_error = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready, a_done, b_done;
    logic [7:0] a_led, b_led;

    int n_pass  = 0;
    int n_total = 0;

    vec_t qa[$];
    vec_t qb[$];

    always #5 clk = ~clk;

    code_led_decoder #(.HOLD_CYCLES(16), .BLINK_HALF(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .code_i(a_code), .error_i(a_error),
        .valid_i(a_valid), .ready_o(a_ready), .led_o(a_led), .done_o(a_done)
    );

    code_led_decoder #(.HOLD_CYCLES(1), .BLINK_HALF(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .code_i(b_code), .error_i(b_error),
        .valid_i(b_valid), .ready_o(b_ready), .led_o(b_led), .done_o(b_done)
    );

    function automatic vec_t mk(string n, logic v, logic e, logic [2:0] c,
                                logic [7:0] l, logic r, logic d);
        vec_t t;
        t.name = n; t.valid = v; t.error = e; t.code = c;
        t.led = l; t.ready = r; t.done = d;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [7:0] led, logic rdy, logic dn,
                         logic [7:0] eled, logic erdy, logic edn);
        n_total++;
        if ({led, rdy, dn} === {eled, erdy, edn}) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got led=%h ready=%b done=%b, expected led=%h ready=%b done=%b",
                     name, idx, led, rdy, dn, eled, erdy, edn);
        end
    endtask

    // Blink pattern seen k cycles after an error accept (HALF=4)
    function automatic logic [7:0] blink_pat(int k);
        return (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
    endfunction

    initial begin
        // T1: single show of code 5
        qa.push_back(mk("T1", 1, 0, 3'd5, 8'h20, 0, 0));
        for (int k = 1; k < 16; k++) qa.push_back(mk("T1", 0, 0, 3'd0, 8'h20, 0, 0));
        qa.push_back(mk("T1", 0, 0, 3'd0, 8'h00, 1, 1));
        qa.push_back(mk("T1", 0, 0, 3'd0, 8'h00, 1, 0));
        // T2: error blink, code ignored
        qa.push_back(mk("T2", 1, 1, 3'd3, 8'hFF, 0, 0));
        for (int k = 1; k < 16; k++) qa.push_back(mk("T2", 0, 0, 3'd0, blink_pat(k), 0, 0));
        qa.push_back(mk("T2", 0, 0, 3'd0, 8'h00, 1, 1));
        qa.push_back(mk("T2", 0, 0, 3'd0, 8'h00, 1, 0));
        // T3: requests during SHOW are dropped
        qa.push_back(mk("T3", 1, 0, 3'd1, 8'h02, 0, 0));
        for (int k = 1; k < 16; k++)
            qa.push_back(mk("T3", (k == 5 || k == 10), (k == 10), 3'd7, 8'h02, 0, 0));
        qa.push_back(mk("T3", 0, 0, 3'd0, 8'h00, 1, 1));
        qa.push_back(mk("T3", 0, 0, 3'd0, 8'h00, 1, 0));
        // T4: valid held high re-accepts in the done cycle
        qa.push_back(mk("T4", 1, 0, 3'd0, 8'h01, 0, 0));
        for (int k = 1; k < 16; k++) qa.push_back(mk("T4", 1, 0, 3'd0, 8'h01, 0, 0));
        qa.push_back(mk("T4", 1, 0, 3'd0, 8'h00, 1, 1));
        qa.push_back(mk("T4", 1, 0, 3'd0, 8'h01, 0, 0));
        for (int k = 1; k < 16; k++) qa.push_back(mk("T4", 0, 0, 3'd0, 8'h01, 0, 0));
        qa.push_back(mk("T4", 0, 0, 3'd0, 8'h00, 1, 1));
        qa.push_back(mk("T4", 0, 0, 3'd0, 8'h00, 1, 0));

        // T6: HOLD=1 sweep, back-to-back and error
        for (int c = 0; c < 8; c++) begin
            qb.push_back(mk("T6", 1, 0, 3'(c), 8'h01 << c, 0, 0));
            qb.push_back(mk("T6", 0, 0, 3'd0, 8'h00, 1, 1));
        end
        qb.push_back(mk("T6b2b", 1, 0, 3'd3, 8'h08, 0, 0));
        qb.push_back(mk("T6b2b", 1, 0, 3'd4, 8'h00, 1, 1));
        qb.push_back(mk("T6b2b", 1, 0, 3'd4, 8'h10, 0, 0));
        qb.push_back(mk("T6b2b", 0, 0, 3'd0, 8'h00, 1, 1));
        qb.push_back(mk("T6err", 1, 1, 3'd6, 8'hFF, 0, 0));
        qb.push_back(mk("T6err", 0, 0, 3'd0, 8'h00, 1, 1));
        qb.push_back(mk("T6err", 0, 0, 3'd0, 8'h00, 1, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", 0, a_led, a_ready, a_done, 8'h00, 1, 0);
        check("rst_b", 0, b_led, b_ready, b_done, 8'h00, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_a", 0, a_led, a_ready, a_done, 8'h00, 1, 0);
        check("rel_b", 0, b_led, b_ready, b_done, 8'h00, 1, 0);

        for (int i = 0; i < qa.size(); i++) begin
            @(negedge clk);
            a_valid = qa[i].valid; a_error = qa[i].error; a_code = qa[i].code;
            @(posedge clk); #1;
            check(qa[i].name, i, a_led, a_ready, a_done, qa[i].led, qa[i].ready, qa[i].done);
        end
        @(negedge clk);
        a_valid = 1'b0; a_error = 1'b0; a_code = '0;

        for (int i = 0; i < qb.size(); i++) begin
            @(negedge clk);
            b_valid = qb[i].valid; b_error = qb[i].error; b_code = qb[i].code;
            @(posedge clk); #1;
            check(qb[i].name, i, b_led, b_ready, b_done, qb[i].led, qb[i].ready, qb[i].done);
        end
        @(negedge clk);
        b_valid = 1'b0; b_error = 1'b0; b_code = '0;

        // T5: asynchronous reset in the middle of SHOW
        @(negedge clk);
        a_valid = 1'b1; a_code = 3'd2;
        @(posedge clk); #1;
        check("T5acc", 0, a_led, a_ready, a_done, 8'h04, 0, 0);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("T5mid", 0, a_led, a_ready, a_done, 8'h04, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("T5async", 0, a_led, a_ready, a_done, 8'h00, 1, 0);
        @(posedge clk); #1;
        check("T5hold", 0, a_led, a_ready, a_done, 8'h00, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            check("T5after", k, a_led, a_ready, a_done, 8'h00, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
